// File: rtl/riscv_test_monitor_if.sv
// CPU data-memory store bus as seen by the test monitor.
// The CPU side drives every signal; the monitor only observes and never stalls the bus.
interface riscv_test_monitor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_dmem_addr;
    logic            i_dmem_wr_en;
    logic [3:0]      i_dmem_byte_sel;
    logic [XLEN-1:0] i_dmem_wr_data;

    modport master (
        output i_dmem_addr,
        output i_dmem_wr_en,
        output i_dmem_byte_sel,
        output i_dmem_wr_data
    );

    modport slave (
        input i_dmem_addr,
        input i_dmem_wr_en,
        input i_dmem_byte_sel,
        input i_dmem_wr_data
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// Watches CPU stores for a full-word result write and ends in PASS, FAIL or TIMEOUT.
// Outputs are registered, so results show one edge after the store; the monitor never stalls the bus.
module riscv_test_monitor #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] PASS_ADDR      = 100,
    parameter logic [XLEN-1:0] PASS_DATA      = 25,
    parameter int unsigned     TIMEOUT_CYCLES = 200
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    riscv_test_monitor_if.slave        dmem,
    output logic [2:0]                 o_state,
    output logic                       o_done,
    output logic                       o_pass,
    output logic [XLEN-1:0]            o_fail_data,
    output logic [31:0]                o_cycle_cnt,
    output logic [15:0]                o_store_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e          state_q,     state_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic [15:0]     store_cnt_q, store_cnt_d;
    logic [XLEN-1:0] fail_data_q, fail_data_d;
    logic            done_q,      done_d;
    logic            pass_q,      pass_d;
    logic            hit;

    // Only a full-word store to the result address decides the test.
    assign hit = dmem.i_dmem_wr_en
              && (dmem.i_dmem_addr == PASS_ADDR)
              && (dmem.i_dmem_byte_sel == 4'b1111);

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        store_cnt_d = store_cnt_q;
        fail_data_d = fail_data_q;

        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
                if (dmem.i_dmem_wr_en && (store_cnt_q != 16'hFFFF)) begin
                    store_cnt_d = store_cnt_q + 16'd1;
                end
                // A hit outranks the timeout on the same edge.
                if (hit) begin
                    if (dmem.i_dmem_wr_data == PASS_DATA) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_data_d = dmem.i_dmem_wr_data;
                    end
                end else if (cycle_cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: ;
            default: begin
                state_d     = ST_IDLE;
                cycle_cnt_d = '0;
                store_cnt_d = '0;
                fail_data_d = '0;
            end
        endcase

        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
        pass_d = (state_d == ST_PASS);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            store_cnt_q <= '0;
            fail_data_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            store_cnt_q <= store_cnt_d;
            fail_data_q <= fail_data_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign o_state     = state_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_fail_data = fail_data_q;
    assign o_cycle_cnt = cycle_cnt_q;
    assign o_store_cnt = store_cnt_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: a reference model pushes the expected output snapshot per edge,
// and each scenario pops and compares it after the edge.
module tb_riscv_test_monitor;

    typedef logic [84:0] snap_t;

    logic        i_clk;
    logic        i_rstn;
    logic [2:0]  o_state;
    logic        o_done;
    logic        o_pass;
    logic [31:0] o_fail_data;
    logic [31:0] o_cycle_cnt;
    logic [15:0] o_store_cnt;

    int errors = 0;
    int checks = 0;

    snap_t sb[$];
    snap_t exp_s;

    logic [2:0]  m_st;
    logic [31:0] m_cyc;
    logic [31:0] m_fd;
    logic [15:0] m_sc;

    riscv_test_monitor_if #(.XLEN(32)) dmem_if ();

    riscv_test_monitor #(
        .XLEN(32), .PASS_ADDR(32'd100), .PASS_DATA(32'd25), .TIMEOUT_CYCLES(200)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .dmem        (dmem_if),
        .o_state     (o_state),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_fail_data (o_fail_data),
        .o_cycle_cnt (o_cycle_cnt),
        .o_store_cnt (o_store_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic snap_t dut_snap();
        return {o_state, o_done, o_pass, o_fail_data, o_cycle_cnt, o_store_cnt};
    endfunction

    function automatic snap_t model_snap();
        logic done;
        done = (m_st == 3'd2) || (m_st == 3'd3) || (m_st == 3'd4);
        return {m_st, done, (m_st == 3'd2), m_fd, m_cyc, m_sc};
    endfunction

    function automatic void model_reset();
        m_st  = 3'd0;
        m_cyc = 32'd0;
        m_fd  = 32'd0;
        m_sc  = 16'd0;
    endfunction

    function automatic void model_step(input logic wr, input logic [31:0] addr,
                                       input logic [3:0] bs, input logic [31:0] data);
        logic        hit;
        logic [31:0] old_cyc;
        hit     = wr && (addr == 32'd100) && (bs == 4'hF);
        old_cyc = m_cyc;
        if (m_st == 3'd0) begin
            m_st = 3'd1;
        end else if (m_st == 3'd1) begin
            m_cyc = m_cyc + 1;
            if (wr && m_sc != 16'hFFFF) m_sc = m_sc + 1;
            if (hit && data == 32'd25) m_st = 3'd2;
            else if (hit) begin
                m_st = 3'd3;
                m_fd = data;
            end else if (old_cyc == 32'd199) m_st = 3'd4;
        end
    endfunction

    // Drive one bus beat at the falling edge and queue what the monitor should show after the next rise.
    task automatic drive(input logic wr, input logic [31:0] addr,
                         input logic [3:0] bs, input logic [31:0] data);
        @(negedge i_clk);
        dmem_if.i_dmem_wr_en    = wr;
        dmem_if.i_dmem_addr     = addr;
        dmem_if.i_dmem_byte_sel = bs;
        dmem_if.i_dmem_wr_data  = data;
        model_step(wr, addr, bs, data);
        sb.push_back(model_snap());
    endtask

    task automatic do_reset(input int n);
        @(negedge i_clk);
        i_rstn = 1'b0;
        dmem_if.i_dmem_wr_en = 1'b0;
        model_reset();
        repeat (n) @(posedge i_clk);
        #1 i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        dmem_if.i_dmem_wr_en    = 1'b1;
        dmem_if.i_dmem_addr     = 32'd100;
        dmem_if.i_dmem_byte_sel = 4'hF;
        dmem_if.i_dmem_wr_data  = 32'd25;
        i_rstn = 1'b1;
        #1 i_rstn = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model_snap());
            if (i > 0) @(posedge i_clk);
            #1;
            exp_s = sb.pop_front();
            checks++;
            if (dut_snap() !== exp_s) begin
                errors++;
                $display("FAIL reset_hold[%0d] got=%h expected=%h", i, dut_snap(), exp_s);
            end
        end
        dmem_if.i_dmem_wr_en = 1'b0;
    endtask

    task automatic test_pass_run();
        do_reset(4);
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 5 || i == 7) drive(1'b1, 32'd104 + i, 4'hF, 32'(i));
            else if (i >= 11)               drive(1'b1, 32'd100, 4'hF, (i == 13) ? 32'd7 : 32'd25);
            else                            drive(1'b0, 32'd0, 4'h0, 32'd0);
            @(posedge i_clk); #1;
            exp_s = sb.pop_front();
            checks++;
            if (dut_snap() !== exp_s) begin
                errors++;
                $display("FAIL pass_run[%0d] got=%h expected=%h", i, dut_snap(), exp_s);
            end
        end
        checks++;
        if ({o_state, o_pass, o_done, o_store_cnt, o_cycle_cnt} !== {3'd2, 1'b1, 1'b1, 16'd4, 32'd11}) begin
            errors++;
            $display("FAIL pass_final state=%0d pass=%b done=%b stores=%0d cycles=%0d expected 2 1 1 4 11",
                     o_state, o_pass, o_done, o_store_cnt, o_cycle_cnt);
        end
    endtask

    task automatic test_fail_run();
        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            if (i == 4)      drive(1'b1, 32'd100, 4'hF, 32'd7);
            else if (i == 6) drive(1'b1, 32'd100, 4'hF, 32'd25);
            else             drive(1'b0, 32'd0, 4'h0, 32'd0);
            @(posedge i_clk); #1;
            exp_s = sb.pop_front();
            checks++;
            if (dut_snap() !== exp_s) begin
                errors++;
                $display("FAIL fail_run[%0d] got=%h expected=%h", i, dut_snap(), exp_s);
            end
        end
        checks++;
        if ({o_state, o_pass, o_done, o_fail_data, o_cycle_cnt} !== {3'd3, 1'b0, 1'b1, 32'd7, 32'd4}) begin
            errors++;
            $display("FAIL fail_final state=%0d pass=%b done=%b data=%0d cycles=%0d expected 3 0 1 7 4",
                     o_state, o_pass, o_done, o_fail_data, o_cycle_cnt);
        end
    endtask

    task automatic test_timeout();
        int first_to;
        first_to = -1;
        do_reset(2);
        for (int i = 0; i < 206; i++) begin
            if (i % 50 == 7) drive(1'b1, 32'd96, 4'hF, 32'd25);
            else             drive(1'b0, 32'd0, 4'h0, 32'd0);
            @(posedge i_clk); #1;
            exp_s = sb.pop_front();
            checks++;
            if (dut_snap() !== exp_s) begin
                errors++;
                $display("FAIL timeout_run[%0d] got=%h expected=%h", i, dut_snap(), exp_s);
            end
            if (o_state == 3'd4 && first_to < 0) first_to = i;
        end
        checks++;
        if (first_to != 200 || o_cycle_cnt !== 32'd200) begin
            errors++;
            $display("FAIL timeout_edge edge=%0d cycles=%0d expected 200 200", first_to, o_cycle_cnt);
        end
    endtask

    task automatic test_collision_partial();
        do_reset(2);
        for (int i = 0; i < 203; i++) begin
            if (i == 5)        drive(1'b1, 32'd100, 4'b0001, 32'd25);
            else if (i == 200) drive(1'b1, 32'd100, 4'hF, 32'd25);
            else               drive(1'b0, 32'd0, 4'h0, 32'd0);
            @(posedge i_clk); #1;
            exp_s = sb.pop_front();
            checks++;
            if (dut_snap() !== exp_s) begin
                errors++;
                $display("FAIL collision_run[%0d] got=%h expected=%h", i, dut_snap(), exp_s);
            end
            if (i == 5) begin
                checks++;
                if (o_state !== 3'd1 || o_store_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL partial_store state=%0d stores=%0d expected 1 1", o_state, o_store_cnt);
                end
            end
        end
        checks++;
        if (o_state !== 3'd2 || o_cycle_cnt !== 32'd200) begin
            errors++;
            $display("FAIL collision_final state=%0d cycles=%0d expected 2 200", o_state, o_cycle_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) drive(1'b1, 32'd8, 4'hF, 32'd1);
            else        drive(1'b0, 32'd0, 4'h0, 32'd0);
            @(posedge i_clk); #1;
            exp_s = sb.pop_front();
            checks++;
            if (dut_snap() !== exp_s) begin
                errors++;
                $display("FAIL async_pre[%0d] got=%h expected=%h", i, dut_snap(), exp_s);
            end
        end
        // Pull reset 3ns after a rising edge and look well before the next one.
        #2 i_rstn = 1'b0;
        model_reset();
        sb.push_back(model_snap());
        #1;
        exp_s = sb.pop_front();
        checks++;
        if (dut_snap() !== exp_s) begin
            errors++;
            $display("FAIL async_clear got=%h expected=%h", dut_snap(), exp_s);
        end
        i_rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) drive(1'b1, 32'd100, 4'hF, 32'd25);
            else        drive(1'b0, 32'd0, 4'h0, 32'd0);
            @(posedge i_clk); #1;
            exp_s = sb.pop_front();
            checks++;
            if (dut_snap() !== exp_s) begin
                errors++;
                $display("FAIL async_post[%0d] got=%h expected=%h", i, dut_snap(), exp_s);
            end
        end
        checks++;
        if (o_state !== 3'd2 || o_cycle_cnt !== 32'd8 || o_store_cnt !== 16'd1) begin
            errors++;
            $display("FAIL async_pass state=%0d cycles=%0d stores=%0d expected 2 8 1",
                     o_state, o_cycle_cnt, o_store_cnt);
        end
    endtask

    initial begin
        dmem_if.i_dmem_wr_en    = 1'b0;
        dmem_if.i_dmem_addr     = '0;
        dmem_if.i_dmem_byte_sel = '0;
        dmem_if.i_dmem_wr_data  = '0;
        model_reset();
        test_reset();
        test_pass_run();
        test_fail_run();
        test_timeout();
        test_collision_partial();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
